// File: rtl/ifm_row_fetcher_pkg.sv
// ifm_row_fetcher_pkg: shared types and default widths for the IFM row fetcher.
// Provides the FSM state encoding, the one-hot row-buffer select helper and
// fallbacks for the controller_params.vh defines (W_SIZE, W_CHANNEL, IFM_DW).
// Optional feature macro used by the fetcher: ROW_FETCH_ZERO_PAD_EN.

`ifndef W_SIZE
`define W_SIZE 10
`endif
`ifndef W_CHANNEL
`define W_CHANNEL 10
`endif
`ifndef IFM_DW
`define IFM_DW 32
`endif

package ifm_row_fetcher_pkg;

   localparam int W_SIZE_DEF    = `W_SIZE;
   localparam int W_CHANNEL_DEF = `W_CHANNEL;
   localparam int IFM_DW_DEF    = `IFM_DW;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Buffer index 3 selects no buffer at all.
   function automatic logic [2:0] buf_onehot(input logic [1:0] b);
      logic [2:0] oh;
      oh = 3'b000;
      case (b)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/ifm_row_fetcher.sv
// ifm_row_fetcher: copies one input-feature-map row (width*channel words) from
// the IFM buffer into one of three row buffers, one word per cycle.
// Ports: clk/rstn; q_width/q_height/q_channel tile geometry; m_req_load/row/buf
// request; o_req_done/o_busy status; o_ifm_rd_addr/i_ifm_rd_data IFM read port
// (1-cycle read latency); o_rb_we (one-hot)/o_rb_addr/o_rb_data row-buffer write.
// Latency: request cycle 0, writes cycles 3..2+N, done pulse cycle 3+N.
// Optional macro ROW_FETCH_ZERO_PAD_EN: rows at or beyond q_height are written
// as N zero words instead of being skipped.

module ifm_row_fetcher
   import ifm_row_fetcher_pkg::*;
#(
   parameter int W_SIZE    = W_SIZE_DEF,
   parameter int W_CHANNEL = W_CHANNEL_DEF,
   parameter int IFM_DW    = IFM_DW_DEF,
   parameter int IFM_AW    = 16,
   parameter int ROW_AW    = 11,
   parameter int ROW_DEPTH = 1536
)(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [W_SIZE-1:0]    q_width,
   input  logic [W_SIZE-1:0]    q_height,
   input  logic [W_CHANNEL-1:0] q_channel,
   input  logic                 m_req_load,
   input  logic [W_SIZE-1:0]    m_req_row,
   input  logic [1:0]           m_req_buf,
   output logic                 o_req_done,
   output logic                 o_busy,
   output logic [IFM_AW-1:0]    o_ifm_rd_addr,
   input  logic [IFM_DW-1:0]    i_ifm_rd_data,
   output logic [2:0]           o_rb_we,
   output logic [ROW_AW-1:0]    o_rb_addr,
   output logic [IFM_DW-1:0]    o_rb_data
);

   // Products are formed wide enough never to overflow, then truncated.
   localparam int                PW      = W_SIZE + W_CHANNEL + IFM_AW;
   localparam logic [IFM_AW-1:0] DEPTH_W = IFM_AW'(ROW_DEPTH);

   state_t                state_q, state_d;
   logic [W_SIZE-1:0]     row_q, width_q, height_q;
   logic [W_CHANNEL-1:0]  chan_q;
   logic [1:0]            buf_q;
   logic [IFM_AW-1:0]     n_q, base_q, k_q;
   logic                  pad_q;
   logic                  wr_vld_q;
   logic [ROW_AW-1:0]     wr_addr_q;

   logic [IFM_AW-1:0]     n_raw, n_clamp, base_calc;
   logic                  row_oob, skip, pad_d, last_k;

   // Row stride uses the unclamped (truncated) word count; only the copy
   // length is limited to the row buffer depth.
   assign n_raw     = IFM_AW'(PW'(width_q) * PW'(chan_q));
   assign n_clamp   = (n_raw > DEPTH_W) ? DEPTH_W : n_raw;
   assign base_calc = IFM_AW'(PW'(row_q) * PW'(n_raw));
   assign row_oob   = (row_q >= height_q);
   assign last_k    = (k_q == (n_q - IFM_AW'(1)));

`ifdef ROW_FETCH_ZERO_PAD_EN
   assign skip  = (n_clamp == '0) || (buf_q == 2'd3);
   assign pad_d = row_oob;
`else
   assign skip  = (n_clamp == '0) || (buf_q == 2'd3) || row_oob;
   assign pad_d = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (m_req_load) state_d = ST_PREP;
         ST_PREP:  state_d = skip ? ST_DONE : ST_READ;
         ST_READ:  if (last_k) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request latch, address counter and one-stage write pipeline
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row_q     <= '0;
         width_q   <= '0;
         height_q  <= '0;
         chan_q    <= '0;
         buf_q     <= '0;
         n_q       <= '0;
         base_q    <= '0;
         k_q       <= '0;
         pad_q     <= 1'b0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         if (state_q == ST_IDLE && m_req_load) begin
            row_q    <= m_req_row;
            width_q  <= q_width;
            height_q <= q_height;
            chan_q   <= q_channel;
            buf_q    <= m_req_buf;
         end
         if (state_q == ST_PREP) begin
            n_q    <= n_clamp;
            base_q <= base_calc;
            pad_q  <= pad_d;
            k_q    <= '0;
         end else if (state_q == ST_READ) begin
            k_q <= k_q + IFM_AW'(1);
         end
         // Read data for address k returns next cycle, so the write for k
         // is issued one cycle behind the read.
         wr_vld_q  <= (state_q == ST_READ);
         wr_addr_q <= ROW_AW'(k_q);
      end
   end

   // Outputs
   always_comb begin
      o_busy        = (state_q != ST_IDLE);
      o_req_done    = (state_q == ST_DONE);
      o_ifm_rd_addr = '0;
      if (state_q == ST_READ && !pad_q) o_ifm_rd_addr = base_q + k_q;
      o_rb_we   = wr_vld_q ? buf_onehot(buf_q) : 3'b000;
      o_rb_addr = wr_vld_q ? wr_addr_q : '0;
      o_rb_data = (wr_vld_q && !pad_q) ? i_ifm_rd_data : '0;
   end

endmodule

// File: tb/tb_ifm_row_fetcher.sv
// tb_ifm_row_fetcher: directed self-checking bench for ifm_row_fetcher.
// Cycle 0 is the cycle m_req_load is high; outputs are sampled at negedge.
// Optional macro ROW_FETCH_ZERO_PAD_EN selects the padding expectations.

module tb_ifm_row_fetcher;

   localparam int W_SIZE = 10, W_CHANNEL = 10, IFM_DW = 32;
   localparam int IFM_AW = 16, ROW_AW = 11, ROW_DEPTH = 1536;
   localparam int MAXC = 1600;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic [W_SIZE-1:0]    q_width = '0, q_height = '0, m_req_row = '0;
   logic [W_CHANNEL-1:0] q_channel = '0;
   logic                 m_req_load = 1'b0;
   logic [1:0]           m_req_buf = '0;
   logic                 o_req_done, o_busy;
   logic [IFM_AW-1:0]    o_ifm_rd_addr;
   logic [IFM_DW-1:0]    i_ifm_rd_data = '0;
   logic [2:0]           o_rb_we;
   logic [ROW_AW-1:0]    o_rb_addr;
   logic [IFM_DW-1:0]    o_rb_data;

   ifm_row_fetcher #(
      .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .IFM_DW(IFM_DW),
      .IFM_AW(IFM_AW), .ROW_AW(ROW_AW), .ROW_DEPTH(ROW_DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn),
      .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
      .m_req_load(m_req_load), .m_req_row(m_req_row), .m_req_buf(m_req_buf),
      .o_req_done(o_req_done), .o_busy(o_busy),
      .o_ifm_rd_addr(o_ifm_rd_addr), .i_ifm_rd_data(i_ifm_rd_data),
      .o_rb_we(o_rb_we), .o_rb_addr(o_rb_addr), .o_rb_data(o_rb_data)
   );

   always #5 clk = ~clk;

   function automatic logic [IFM_DW-1:0] mem_f(input logic [IFM_AW-1:0] a);
      return {16'hC0DE, a};
   endfunction

   // IFM buffer model: data for an address appears one cycle later.
   always @(posedge clk) i_ifm_rd_data <= mem_f(o_ifm_rd_addr);

   integer tests = 0, fails = 0;
   int wr_cnt, done_cnt, done_cyc;
   logic [2:0]        we_log   [0:MAXC-1];
   logic [ROW_AW-1:0] addr_log [0:MAXC-1];
   logic [IFM_DW-1:0] dat_log  [0:MAXC-1];
   logic [IFM_AW-1:0] rd_log   [0:MAXC-1];
   logic              busy_log [0:MAXC-1];

   // Drives one request at cycle 0 and records ncyc cycles of outputs.
   // Must be entered #1 after a rising edge; returns at the same phase.
   task automatic run(input int row, input int bufi, input int w, input int h,
                      input int ch, input int extra_load, input int rst_cyc,
                      input int ncyc);
      m_req_row = W_SIZE'(row);
      m_req_buf = 2'(bufi);
      q_width   = W_SIZE'(w);
      q_height  = W_SIZE'(h);
      q_channel = W_CHANNEL'(ch);
      wr_cnt = 0; done_cnt = 0; done_cyc = -1;
      for (int c = 0; c < ncyc; c++) begin
         m_req_load = (c == 0) || (c == extra_load);
         if (c == rst_cyc) rstn = 1'b0;
         if (c == rst_cyc + 1) rstn = 1'b1;
         @(negedge clk);
         we_log[c] = o_rb_we; addr_log[c] = o_rb_addr; dat_log[c] = o_rb_data;
         rd_log[c] = o_ifm_rd_addr; busy_log[c] = o_busy;
         if (o_rb_we != 3'b000) wr_cnt++;
         if (o_req_done) begin done_cnt++; done_cyc = c; end
         @(posedge clk); #1;
      end
      m_req_load = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if ({o_busy, o_req_done, o_rb_we} !== 5'b0 || o_ifm_rd_addr !== '0 ||
          o_rb_addr !== '0 || o_rb_data !== '0) begin
         fails++;
         $display("FAIL reset_outputs: busy=%b done=%b we=%b rd=%0h got nonzero, want all 0",
                  o_busy, o_req_done, o_rb_we, o_ifm_rd_addr);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (o_busy !== 1'b0) begin
         fails++; $display("FAIL reset_idle_busy: got %b want 0", o_busy);
      end
   endtask

   task automatic test_basic();
      run(1, 2, 4, 8, 2, -1, -10, 12);
      for (int c = 0; c < 12; c++) begin
         logic [2:0] ew;
         ew = (c >= 3 && c <= 10) ? 3'b100 : 3'b000;
         tests++;
         if (we_log[c] !== ew) begin
            fails++; $display("FAIL basic_we c%0d: got %b want %b", c, we_log[c], ew);
         end
         if (ew != 3'b000) begin
            tests++;
            if (addr_log[c] !== ROW_AW'(c - 3) || dat_log[c] !== mem_f(IFM_AW'(8 + c - 3))) begin
               fails++;
               $display("FAIL basic_wr c%0d: got addr %0d data %h want addr %0d data %h",
                        c, addr_log[c], dat_log[c], c - 3, mem_f(IFM_AW'(8 + c - 3)));
            end
         end
         tests++;
         if (busy_log[c] !== (c != 0)) begin
            fails++; $display("FAIL basic_busy c%0d: got %b want %b", c, busy_log[c], c != 0);
         end
      end
      for (int c = 2; c <= 9; c++) begin
         tests++;
         if (rd_log[c] !== IFM_AW'(8 + c - 2)) begin
            fails++; $display("FAIL basic_rd c%0d: got %0d want %0d", c, rd_log[c], 8 + c - 2);
         end
      end
      tests++;
      if (done_cnt !== 1 || done_cyc !== 11) begin
         fails++; $display("FAIL basic_done: got %0d pulses at c%0d want 1 at c11", done_cnt, done_cyc);
      end
   endtask

   task automatic test_single();
      run(0, 0, 1, 4, 1, -1, -10, 5);
      tests++;
      if (rd_log[2] !== 16'd0 || we_log[3] !== 3'b001 || addr_log[3] !== '0 ||
          dat_log[3] !== mem_f(16'd0)) begin
         fails++;
         $display("FAIL single_xfer: got rd %0d we %b addr %0d data %h want 0 001 0 %h",
                  rd_log[2], we_log[3], addr_log[3], dat_log[3], mem_f(16'd0));
      end
      tests++;
      if (wr_cnt !== 1 || done_cnt !== 1 || done_cyc !== 4) begin
         fails++; $display("FAIL single_done: got wr %0d done %0d@c%0d want 1 1@c4",
                           wr_cnt, done_cnt, done_cyc);
      end
   endtask

   task automatic test_ignore_busy_req();
      run(1, 1, 4, 8, 2, 4, -10, 16);
      tests++;
      if (wr_cnt !== 8 || done_cnt !== 1 || done_cyc !== 11) begin
         fails++; $display("FAIL ignore_req: got wr %0d done %0d@c%0d want 8 1@c11",
                           wr_cnt, done_cnt, done_cyc);
      end
      tests++;
      if (we_log[3] !== 3'b010 || busy_log[12] !== 1'b0 || busy_log[15] !== 1'b0) begin
         fails++; $display("FAIL ignore_state: got we %b busy12 %b busy15 %b want 010 0 0",
                           we_log[3], busy_log[12], busy_log[15]);
      end
   endtask

   task automatic test_out_of_range_row();
      run(4, 0, 3, 4, 1, -1, -10, 10);
`ifdef ROW_FETCH_ZERO_PAD_EN
      tests++;
      if (wr_cnt !== 3 || done_cnt !== 1 || done_cyc !== 6) begin
         fails++; $display("FAIL pad_done: got wr %0d done %0d@c%0d want 3 1@c6",
                           wr_cnt, done_cnt, done_cyc);
      end
      for (int c = 3; c <= 5; c++) begin
         tests++;
         if (we_log[c] !== 3'b001 || addr_log[c] !== ROW_AW'(c - 3) || dat_log[c] !== '0) begin
            fails++; $display("FAIL pad_wr c%0d: got we %b addr %0d data %h want 001 %0d 0",
                              c, we_log[c], addr_log[c], dat_log[c], c - 3);
         end
      end
`else
      tests++;
      if (wr_cnt !== 0 || done_cnt !== 1 || done_cyc !== 2) begin
         fails++; $display("FAIL oob_skip: got wr %0d done %0d@c%0d want 0 1@c2",
                           wr_cnt, done_cnt, done_cyc);
      end
`endif
   endtask

   task automatic test_reset_mid();
      run(1, 0, 4, 8, 2, -1, 5, 14);
      tests++;
      if (we_log[5] !== 3'b000 || busy_log[5] !== 1'b0 || rd_log[5] !== '0) begin
         fails++; $display("FAIL rst_mid_out: got we %b busy %b rd %0d want 000 0 0",
                           we_log[5], busy_log[5], rd_log[5]);
      end
      tests++;
      if (done_cnt !== 0 || wr_cnt !== 2) begin
         fails++; $display("FAIL rst_mid_abort: got done %0d wr %0d want 0 2", done_cnt, wr_cnt);
      end
      run(1, 0, 4, 8, 2, -1, -10, 12);
      tests++;
      if (wr_cnt !== 8 || done_cyc !== 11 || we_log[3] !== 3'b001 ||
          dat_log[10] !== mem_f(16'd15)) begin
         fails++; $display("FAIL rst_recover: got wr %0d done c%0d we %b data %h want 8 c11 001 %h",
                           wr_cnt, done_cyc, we_log[3], dat_log[10], mem_f(16'd15));
      end
   endtask

   task automatic test_back_to_back();
      run(1, 3, 4, 8, 2, -1, -10, 3);
      tests++;
      if (wr_cnt !== 0 || done_cyc !== 2 || busy_log[1] !== 1'b1 || busy_log[2] !== 1'b1) begin
         fails++; $display("FAIL buf3_skip: got wr %0d done c%0d busy %b%b want 0 c2 11",
                           wr_cnt, done_cyc, busy_log[1], busy_log[2]);
      end
      run(2, 1, 1, 4, 1, -1, -10, 5);
      tests++;
      if (rd_log[2] !== 16'd2 || we_log[3] !== 3'b010 || addr_log[3] !== '0 ||
          dat_log[3] !== mem_f(16'd2) || done_cyc !== 4 || wr_cnt !== 1) begin
         fails++; $display("FAIL b2b_xfer: got rd %0d we %b data %h done c%0d wr %0d want 2 010 %h c4 1",
                           rd_log[2], we_log[3], dat_log[3], done_cyc, wr_cnt, mem_f(16'd2));
      end
      run(0, 0, 0, 4, 2, -1, -10, 3);
      tests++;
      if (wr_cnt !== 0 || done_cnt !== 1 || done_cyc !== 2) begin
         fails++; $display("FAIL zero_len: got wr %0d done %0d@c%0d want 0 1@c2",
                           wr_cnt, done_cnt, done_cyc);
      end
   endtask

   task automatic test_clamp();
      // 768*3 = 2304 words, limited to the 1536-word row buffer.
      run(0, 0, 768, 4, 3, -1, -10, 1541);
      tests++;
      if (wr_cnt !== 1536 || done_cyc !== 1539) begin
         fails++; $display("FAIL clamp_len: got wr %0d done c%0d want 1536 c1539", wr_cnt, done_cyc);
      end
      tests++;
      if (we_log[1538] !== 3'b001 || addr_log[1538] !== 11'd1535 ||
          dat_log[1538] !== mem_f(16'd1535) || rd_log[1537] !== 16'd1535) begin
         fails++; $display("FAIL clamp_last: got we %b addr %0d data %h rd %0d want 001 1535 %h 1535",
                           we_log[1538], addr_log[1538], dat_log[1538], rd_log[1537], mem_f(16'd1535));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_ignore_busy_req();
      test_out_of_range_row();
      test_reset_mid();
      test_back_to_back();
      test_clamp();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifm_row_fetcher.md
IFM_ROW_FETCHER -- requirements
Module: ifm_row_fetcher

Interface
REQ-001 SHALL have parameters: W_SIZE, `W_SIZE, spatial index width; W_CHANNEL, `W_CHANNEL, channel width; IFM_DW, `IFM_DW, data width; IFM_AW, 16, IFM buffer address width; ROW_AW, 11, row buffer address width; ROW_DEPTH, 1536, row buffer words.
REQ-002 SHALL have ports: clk input 1 clock; rstn input 1 async active-low reset.
REQ-003 SHALL have ports: q_width input W_SIZE columns; q_height input W_SIZE rows; q_channel input W_CHANNEL tiled channels.
REQ-004 SHALL have ports: m_req_load input 1 row-load request pulse; m_req_row input W_SIZE row index; m_req_buf input 2 target row buffer 0..2.
REQ-005 SHALL have ports: o_req_done output 1 one-cycle completion pulse; o_busy output 1 request in progress.
REQ-006 SHALL have ports: o_ifm_rd_addr output IFM_AW read address; i_ifm_rd_data input IFM_DW read data, valid 1 cycle after address.
REQ-007 SHALL have ports: o_rb_we output 3 one-hot row buffer write enable; o_rb_addr output ROW_AW write address; o_rb_data output IFM_DW write data.

Function
REQ-008 SHALL use FSM IDLE -> PREP -> READ -> DRAIN -> DONE -> IDLE.
REQ-009 SHALL accept m_req_load only in IDLE; latch row, buf, q_width, q_height, q_channel; requests outside IDLE are ignored.
REQ-010 SHALL in PREP register N = q_width*q_channel and base = m_req_row*N, both truncated to IFM_AW bits; N clamped to ROW_DEPTH.
REQ-011 SHALL in READ issue o_ifm_rd_addr = base+k for k = 0..N-1, one per cycle, no bubbles.
REQ-012 SHALL write i_ifm_rd_data to o_rb_addr = k one cycle after address k, o_rb_we = one-hot(buf).
REQ-013 SHALL take DRAIN for exactly one cycle to complete the final write, then DONE pulses o_req_done for one cycle.
REQ-014 SHALL give latency: request cycle 0, first write cycle 3, last write cycle 2+N, o_req_done cycle 3+N.
REQ-015 SHALL hold o_busy high from cycle 1 through the DONE cycle inclusive.
REQ-016 SHALL, when N == 0 or m_req_buf == 3, go PREP -> DONE with no writes; done at cycle 2.
REQ-017 SHALL keep o_rb_we zero whenever no valid write is in flight; o_rb_addr/o_rb_data don't-care then.
REQ-018 SHALL accept a new request in the IDLE cycle immediately after DONE.

Reset
REQ-019 SHALL reset all outputs to zero and FSM to IDLE asynchronously on rstn low, including mid-transfer; the aborted request produces no o_req_done.

Configuration
REQ-020 SHALL, with ROW_FETCH_ZERO_PAD_EN defined, treat m_req_row >= q_height as padding: no IFM reads, write zeros to addresses 0..N-1 at one per cycle, same latency as REQ-014.
REQ-021 SHALL, without ROW_FETCH_ZERO_PAD_EN, treat m_req_row >= q_height per REQ-016 (no writes, done at cycle 2).

Structure
REQ-022 SHALL take W_SIZE, W_CHANNEL, IFM_DW, FSM state encodings from controller_params.vh.
REQ-023 SHALL be a single module; no sub-module required (address counter and write pipeline inline).

Verification
REQ-024 SHALL cover: width 4, channel 2, row 1, buf 2 -> reads addr 8..15, o_rb_we=3'b100 addr 0..7 cycles 3..10, o_req_done cycle 11.
REQ-025 SHALL cover: row 0 width 1 channel 1 buf 0 -> single read addr 0, one write addr 0, done cycle 4.
REQ-026 SHALL cover: second m_req_load during READ -> ignored; exactly one done pulse, write count unchanged.
REQ-027 SHALL cover: q_height 4, row 4, width 3, channel 1 -> with macro 3 zero writes, done cycle 6; without macro no writes, done cycle 2.
REQ-028 SHALL cover: rstn low at cycle 5 of an 8-word transfer -> o_rb_we, o_busy zero immediately, no done; next request completes normally.
REQ-029 SHALL cover: m_req_buf = 3 -> no writes, done cycle 2; back-to-back requests on cycles immediately after each DONE.
